boot_rom_ctrl: RTL and testbench

Parametrised boot ROM front-end, the next generation of the SoC boot ROM wrapper. Sits between the TCDM/XBAR slave port and a synchronous ROM macro (generic or FPGA).
Generalised in data width and ROM depth, with these additions:
- explicit req/gnt/r_valid handshake
- error response for writes and out-of-range reads
- a small set of programmable, lockable patch slots that override ROM words
- a saturating error counter

---
 rtl/boot_rom_ctrl.sv | 164 ++++++++++++++++
 tb/tb_boot_rom_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_rom_ctrl.sv
// -----------------------------------------------------------------------------
// boot_rom_ctrl
// Boot ROM front-end between a TCDM/XBAR slave port and a synchronous ROM macro.
// Every request is granted at once and answered exactly one cycle later.
// Writes and out-of-range reads get an error response (r_opc_o=1, data 0).
// A small set of lockable patch slots can override individual ROM words.
// A saturating counter tracks how many error responses were issued.
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   test_mode_i               1 = ignore patch slots, return raw ROM data
//   req_i/add_i/wen_i         bus request, byte address, 1=read 0=write
//   wdata_i/be_i              write data / byte enables (unused, always error)
//   gnt_o                     grant, equal to req_i
//   r_valid_o/r_rdata_o/r_opc_o  response valid / data / error flag
//   rom_cen_o/rom_addr_o      ROM chip enable (active-low) and word index
//   rom_rdata_i               ROM data, one cycle after rom_cen_o=0
//   cfg_we_i/cfg_idx_i/cfg_sel_i/cfg_wdata_i  patch slot write port
//   cfg_lock_i/lock_o         sticky lock of the patch slots
//   err_cnt_o                 saturating error response counter
// -----------------------------------------------------------------------------
module boot_rom_ctrl #(
    parameter int unsigned ROM_ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ROM_WORDS      = 2 ** (ROM_ADDR_WIDTH - $clog2(DATA_WIDTH / 8)),
    parameter int unsigned NUM_PATCH      = 4,
    parameter int unsigned ERR_CNT_WIDTH  = 8,
    localparam int unsigned BO            = $clog2(DATA_WIDTH / 8),
    localparam int unsigned IW            = ROM_ADDR_WIDTH - BO
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      test_mode_i,
    input  logic                      req_i,
    input  logic [31:0]               add_i,
    input  logic                      wen_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   be_i,
    output logic                      gnt_o,
    output logic                      r_valid_o,
    output logic [DATA_WIDTH-1:0]     r_rdata_o,
    output logic                      r_opc_o,
    output logic                      rom_cen_o,
    output logic [IW-1:0]             rom_addr_o,
    input  logic [DATA_WIDTH-1:0]     rom_rdata_i,
    input  logic                      cfg_we_i,
    input  logic [3:0]                cfg_idx_i,
    input  logic                      cfg_sel_i,
    input  logic [DATA_WIDTH-1:0]     cfg_wdata_i,
    input  logic                      cfg_lock_i,
    output logic                      lock_o,
    output logic [ERR_CNT_WIDTH-1:0]  err_cnt_o
);

    // Write data and byte enables are never used: every write is an error.
    logic unused_s;
    assign unused_s = ^{wdata_i, be_i, add_i[31:ROM_ADDR_WIDTH], add_i[BO-1:0]};

    logic [IW-1:0]                   idx_s;
    logic                            rd_ok_s;
    logic                            err_s;
    logic                            hit_s;
    logic [DATA_WIDTH-1:0]           hit_data_s;
    logic                            cfg_wr_s;

    logic [NUM_PATCH-1:0]            slot_en_r;
    logic [NUM_PATCH-1:0][IW-1:0]    slot_addr_r;
    logic [NUM_PATCH-1:0][DATA_WIDTH-1:0] slot_data_r;
    logic                            lock_r;

    logic                            r_valid_r;
    logic                            r_opc_r;
    logic                            rom_pend_r;
    logic [DATA_WIDTH-1:0]           data_r;
    logic [ERR_CNT_WIDTH-1:0]        err_cnt_r;

    // Request decode: word index, in-range read, error classification.
    assign idx_s      = add_i[ROM_ADDR_WIDTH-1:BO];
    assign rd_ok_s    = req_i & wen_i & (32'(idx_s) < ROM_WORDS);
    assign err_s      = req_i & ~rd_ok_s;
    assign gnt_o      = req_i;
    assign rom_cen_o  = ~rd_ok_s;
    assign rom_addr_o = rd_ok_s ? idx_s : {IW{1'b0}};

    // Slot writes are dropped once locked or when the index names no slot.
    assign cfg_wr_s = cfg_we_i & ~lock_r & ({1'b0, cfg_idx_i} < 5'(NUM_PATCH));

    // Patch match: scan from the top so the lowest matching slot wins last.
    always_comb begin
        hit_s      = 1'b0;
        hit_data_s = {DATA_WIDTH{1'b0}};
        for (int i = int'(NUM_PATCH) - 1; i >= 0; i--) begin
            if (slot_en_r[i] && (slot_addr_r[i] == idx_s) && !test_mode_i) begin
                hit_s      = 1'b1;
                hit_data_s = slot_data_r[i];
            end else begin
                hit_s      = hit_s;
                hit_data_s = hit_data_s;
            end
        end
    end

    // Patch slot registers and the sticky lock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_en_r   <= {NUM_PATCH{1'b0}};
            slot_addr_r <= {(NUM_PATCH * IW){1'b0}};
            slot_data_r <= {(NUM_PATCH * DATA_WIDTH){1'b0}};
            lock_r      <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_PATCH); i++) begin
                if (cfg_wr_s && (cfg_idx_i == 4'(i))) begin
                    if (cfg_sel_i) begin
                        slot_data_r[i] <= cfg_wdata_i;
                    end else begin
                        slot_en_r[i]   <= cfg_wdata_i[0];
                        slot_addr_r[i] <= cfg_wdata_i[ROM_ADDR_WIDTH-1:BO];
                    end
                end
            end
            // Lock raised together with a write still lets that write land.
            lock_r <= lock_r | cfg_lock_i;
        end
    end

    // Response pipeline stage and saturating error counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_r  <= 1'b0;
            r_opc_r    <= 1'b0;
            rom_pend_r <= 1'b0;
            data_r     <= {DATA_WIDTH{1'b0}};
            err_cnt_r  <= {ERR_CNT_WIDTH{1'b0}};
        end else begin
            r_valid_r  <= req_i;
            r_opc_r    <= err_s;
            rom_pend_r <= rd_ok_s & ~hit_s;
            // data_r carries error/patch data directly and otherwise snapshots
            // the ROM output of a finished ROM response so idle cycles hold it.
            if (err_s) begin
                data_r <= {DATA_WIDTH{1'b0}};
            end else if (rd_ok_s && hit_s) begin
                data_r <= hit_data_s;
            end else if (rom_pend_r) begin
                data_r <= rom_rdata_i;
            end else begin
                data_r <= data_r;
            end
            if (err_s && (err_cnt_r != {ERR_CNT_WIDTH{1'b1}})) begin
                err_cnt_r <= err_cnt_r + ERR_CNT_WIDTH'(1'b1);
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end
    end

    // ROM data is only valid in the response cycle, so it is muxed in live.
    assign r_valid_o = r_valid_r;
    assign r_opc_o   = r_opc_r;
    assign r_rdata_o = rom_pend_r ? rom_rdata_i : data_r;
    assign lock_o    = lock_r;
    assign err_cnt_o = err_cnt_r;

endmodule

// File: tb/tb_boot_rom_ctrl.sv
// -----------------------------------------------------------------------------
// tb_boot_rom_ctrl
// Randomised and directed stimulus for boot_rom_ctrl. Each issued request pushes
// its expected response (from a behavioural model of slots, lock, ROM contents
// and error counter) into a queue; a monitor pops and compares on r_valid_o.
// -----------------------------------------------------------------------------
module tb_boot_rom_ctrl;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam int RW = 1000;
    localparam int NP = 4;
    localparam int EW = 8;
    localparam int IW = 11;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          test_mode = 1'b0;
    logic          req = 1'b0;
    logic [31:0]   add = 32'h0;
    logic          wen = 1'b1;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    be = 4'h0;
    logic          gnt;
    logic          r_valid;
    logic [DW-1:0] r_rdata;
    logic          r_opc;
    logic          rom_cen;
    logic [IW-1:0] rom_addr;
    logic [DW-1:0] rom_rdata = '0;
    logic          cfg_we = 1'b0;
    logic [3:0]    cfg_idx = 4'h0;
    logic          cfg_sel = 1'b0;
    logic [DW-1:0] cfg_wdata = '0;
    logic          cfg_lock = 1'b0;
    logic          lock_o;
    logic [EW-1:0] err_cnt;

    boot_rom_ctrl #(
        .ROM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_WORDS(RW),
        .NUM_PATCH(NP), .ERR_CNT_WIDTH(EW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .test_mode_i(test_mode),
        .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be),
        .gnt_o(gnt), .r_valid_o(r_valid), .r_rdata_o(r_rdata), .r_opc_o(r_opc),
        .rom_cen_o(rom_cen), .rom_addr_o(rom_addr), .rom_rdata_i(rom_rdata),
        .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_sel_i(cfg_sel),
        .cfg_wdata_i(cfg_wdata), .cfg_lock_i(cfg_lock), .lock_o(lock_o),
        .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input int unsigned i);
        if (i == 5) return 32'hDEADBEEF;
        return (i * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // ROM macro: valid data one cycle after an enabled access, garbage otherwise.
    always @(posedge clk) begin
        if (!rom_cen) rom_rdata <= rom_word(int'(rom_addr));
        else          rom_rdata <= $urandom();
    end

    typedef struct {
        int          cyc;
        logic        opc;
        logic [31:0] data;
        int          err;
    } resp_t;

    resp_t       sbq[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] last_rdata = 32'h0;

    bit          m_en[NP];
    int unsigned m_addr[NP];
    logic [31:0] m_data[NP];
    bit          m_lock;
    int          m_err;
    int unsigned pool[4] = '{5, 7, 20, 100};

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_en[i] = 1'b0; m_addr[i] = 0; m_data[i] = 32'h0;
        end
        m_lock = 1'b0;
        m_err  = 0;
    endtask

    // Monitor: pops one expected response per r_valid_o, else checks hold.
    always @(negedge clk) begin
        resp_t e;
        if (rst_ni) begin
            if (r_valid) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_valid: got r_valid=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_cycle", 64'(cyc), 64'(e.cyc + 1));
                    chk("r_opc", 64'(r_opc), 64'(e.opc));
                    chk("r_rdata", 64'(r_rdata), 64'(e.data));
                    chk("err_cnt", 64'(err_cnt), 64'(e.err));
                    last_rdata = e.data;
                end
            end else begin
                chk("rdata_hold", 64'(r_rdata), 64'(last_rdata));
            end
        end
    end

    // One bus cycle: drive inputs, check decode, queue expectation, update model.
    task automatic step(input logic rq, input logic we_n, input int unsigned idx,
                        input logic tm, input logic cwe, input logic [3:0] cidx,
                        input logic csel, input logic [31:0] cw, input logic clk_lock);
        logic [31:0] a;
        bit          rd;
        resp_t       e;
        a = $urandom();
        a[12:2] = idx[10:0];
        req = rq; wen = we_n; add = a; wdata = $urandom(); be = 4'($urandom());
        test_mode = tm; cfg_we = cwe; cfg_idx = cidx; cfg_sel = csel;
        cfg_wdata = cw; cfg_lock = clk_lock;
        @(negedge clk);
        chk("gnt", 64'(gnt), 64'(rq));
        rd = rq && we_n && (idx < RW);
        chk("rom_cen", 64'(rom_cen), 64'(!rd));
        if (rd) chk("rom_addr", 64'(rom_addr), 64'(idx));
        if (rq) begin
            e.cyc = cyc;
            if (!rd) begin
                e.opc = 1'b1; e.data = 32'h0;
                if (m_err < 255) m_err++;
            end else begin
                e.opc = 1'b0; e.data = rom_word(idx);
                for (int i = NP - 1; i >= 0; i--)
                    if (m_en[i] && m_addr[i] == idx && !tm) e.data = m_data[i];
            end
            e.err = m_err;
            sbq.push_back(e);
        end
        if (cwe && !m_lock && cidx < NP) begin
            if (csel) m_data[cidx] = cw;
            else begin m_en[cidx] = cw[0]; m_addr[cidx] = (cw >> 2) & 32'h7FF; end
        end
        if (clk_lock) m_lock = 1'b1;
        @(posedge clk); #1;
        chk("lock_o", 64'(lock_o), 64'(m_lock));
    endtask

    task automatic rd(input int unsigned idx, input logic tm);
        step(1'b1, 1'b1, idx, tm, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0);
    endtask
    task automatic wr(input int unsigned idx);
        step(1'b1, 1'b0, idx, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0);
    endtask
    task automatic cfg(input logic [3:0] cidx, input logic csel, input logic [31:0] cw);
        step(1'b0, 1'b1, 0, 1'b0, 1'b1, cidx, csel, cw, 1'b0);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        int unsigned ridx;
        logic [31:0] cw;
        logic        cs;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_r_valid", 64'(r_valid), 64'd0);
        chk("rst_r_rdata", 64'(r_rdata), 64'd0);
        chk("rst_r_opc", 64'(r_opc), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_lock", 64'(lock_o), 64'd0);
        chk("rst_rom_cen", 64'(rom_cen), 64'd1);
        rst_ni = 1'b1;
        idle(2);

        // Plain ROM read, then patch via slot 2 and bypass it in test mode.
        rd(5, 1'b0);
        cfg(4'd2, 1'b0, (32'd5 << 2) | 32'd1);
        cfg(4'd2, 1'b1, 32'h12345678);
        rd(5, 1'b0);
        rd(5, 1'b1);
        idle(1);

        // Write and out-of-range read both error.
        wr(5);
        rd(1500, 1'b0);
        idle(2);

        // Randomised traffic with occasional slot writes (some to invalid slots).
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 7))
                0, 1:    ridx = pool[$urandom_range(0, 3)];
                2:       ridx = 1000 + $urandom_range(0, 1047);
                default: ridx = $urandom_range(0, 999);
            endcase
            cs = 1'($urandom_range(0, 1));
            cw = $urandom();
            if (!cs) begin
                cw[12:2] = 11'(pool[$urandom_range(0, 3)]);
            end
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0), ridx,
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                 4'($urandom_range(0, 7)), cs, cw, 1'b0);
        end
        idle(2);

        // Counter saturation under back-to-back writes, then back-to-back reads.
        for (int n = 0; n < 300; n++) wr($urandom_range(0, 2047));
        for (int n = 0; n < 10; n++) rd($urandom_range(0, 999), 1'b0);
        idle(2);

        // Priority: slots 1 and 3 both patch idx 7; slot 1 must win.
        for (int i = 0; i < NP; i++) cfg(4'(i), 1'b0, 32'h0);
        cfg(4'd3, 1'b0, (32'd7 << 2) | 32'd1);
        cfg(4'd3, 1'b1, 32'hAAAA3333);
        cfg(4'd1, 1'b0, (32'd7 << 2) | 32'd1);
        cfg(4'd1, 1'b1, 32'hBBBB1111);
        rd(7, 1'b0);
        cfg(4'd9, 1'b1, 32'hCCCC9999);
        rd(7, 1'b0);
        // Read and write of the matching slot in one cycle sees old data.
        step(1'b1, 1'b1, 7, 1'b0, 1'b1, 4'd1, 1'b1, 32'hDDDD2222, 1'b0);
        rd(7, 1'b0);

        // Lock with a same-cycle write (lands), then a later write (dropped).
        cfg(4'd0, 1'b0, (32'd20 << 2) | 32'd1);
        step(1'b0, 1'b1, 0, 1'b0, 1'b1, 4'd0, 1'b1, 32'h22220000, 1'b1);
        cfg(4'd0, 1'b1, 32'h33330000);
        cfg(4'd0, 1'b0, 32'h0);
        rd(20, 1'b0);
        rd(7, 1'b0);
        idle(3);

        // Reset while a response is on the bus: it must vanish at once.
        rd(5, 1'b0);
        chk("pre_rst_valid", 64'(r_valid), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(r_valid), 64'd0);
        chk("mid_rst_rdata", 64'(r_rdata), 64'd0);
        chk("mid_rst_opc", 64'(r_opc), 64'd0);
        chk("mid_rst_err", 64'(err_cnt), 64'd0);
        chk("mid_rst_lock", 64'(lock_o), 64'd0);
        sbq.delete();
        model_reset();
        last_rdata = 32'h0;
        req = 1'b0; cfg_we = 1'b0; cfg_lock = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        idle(3);
        rd(5, 1'b0);
        rd(20, 1'b0);
        idle(3);
        chk("queue_drained", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
